// File: rtl/tile_mem_arbiter.sv
// tile_mem_arbiter: shares the single-port 16x8 tile RAM between the game FSM (port 0),
// the board loader (port 1) and the VGA tile renderer (port 2).
// One access is granted per cycle. A port may lock the RAM for a burst, and a timeout
// forces the lock to release.
// Build option: define TILE_ARB_RR_EN for round-robin arbitration. When it is not
// defined, arbitration uses fixed priority 0 > 1 > 2.
module tile_mem_arbiter #(
   parameter int unsigned AW       = 4,
   parameter int unsigned DW       = 8,
   parameter int unsigned RD_LAT   = 1,
   parameter int unsigned LOCK_MAX = 16
) (
   input  logic            clk,
   input  logic            clear,
   input  logic [2:0]      req,
   input  logic [2:0]      we,
   input  logic [3*AW-1:0] addr,
   input  logic [3*DW-1:0] wdata,
   input  logic [2:0]      lock,
   output logic [2:0]      gnt,
   output logic [2:0]      rvalid,
   output logic [DW-1:0]   rdata,
   output logic            lock_break,
   output logic [AW-1:0]   mem_addr,
   output logic [DW-1:0]   mem_wdata,
   output logic            mem_we,
   input  logic [DW-1:0]   mem_rdata
);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;
   localparam logic [7:0] LCNT_LAST = 8'(LOCK_MAX - 1);

   logic [0:0]    r_state;
   logic [0:0]    w_state_nxt;
   logic [1:0]    r_owner;
   logic [1:0]    w_owner_nxt;
   logic [7:0]    r_lcnt;
   logic [7:0]    w_lcnt_nxt;
   logic          r_lock_break;
   logic          w_break_nxt;
   logic [2:0]    r_rv [RD_LAT];

   logic [1:0]    w_start;
   logic [1:0]    w_idx;
   logic [1:0]    w_win;
   logic          w_any;
   logic [2:0]    w_rd_head;
   logic [AW-1:0] w_addr_p  [3];
   logic [DW-1:0] w_wdata_p [3];

   // Split the flat per-port address and write-data buses into one field per port.
   for (genvar gi = 0; gi < 3; gi++) begin : g_unpack
      assign w_addr_p[gi]  = addr[gi*AW +: AW];
      assign w_wdata_p[gi] = wdata[gi*DW +: DW];
   end

`ifdef TILE_ARB_RR_EN
   logic [1:0] r_ptr;

   // Round-robin pointer: moves past the port served by the last unlocked grant or by the lock that ended.
   always_ff @(posedge clk) begin
      if (!clear) begin
         r_ptr <= 2'd0;
      end else if (w_state_nxt == ST_IDLE && (r_state == ST_LOCKED || w_any)) begin
         r_ptr <= (w_win == 2'd2) ? 2'd0 : w_win + 2'd1;
      end
   end

   assign w_start = r_ptr;
`else
   assign w_start = 2'd0;
`endif

   // Arbitration and lock handling: pick the winner and compute the next FSM state.
   always_comb begin
      w_state_nxt = r_state;
      w_owner_nxt = r_owner;
      w_lcnt_nxt  = r_lcnt;
      w_break_nxt = 1'b0;
      w_win       = 2'd0;
      w_any       = 1'b0;
      w_idx       = 2'd0;
      if (r_state == ST_IDLE) begin
         for (int k = 0; k < 3; k++) begin
            w_idx = 2'((32'(w_start) + 32'(k)) % 32'd3);
            if (!w_any && req[w_idx]) begin
               w_any = 1'b1;
               w_win = w_idx;
            end
         end
         if (w_any && lock[w_win]) begin
            w_state_nxt = ST_LOCKED;
            w_owner_nxt = w_win;
            w_lcnt_nxt  = 8'd1;
         end
      end else begin
         // Only the owner can be served; the lock ends on its request or on timeout.
         w_win      = r_owner;
         w_any      = req[r_owner];
         w_lcnt_nxt = r_lcnt + 8'd1;
         if (r_lcnt == LCNT_LAST) begin
            w_state_nxt = ST_IDLE;
            w_break_nxt = 1'b1;
         end else if (!lock[r_owner]) begin
            w_state_nxt = ST_IDLE;
         end
      end
      if (!clear) begin
         w_any = 1'b0;
      end
   end

   // Drive the grant and the RAM strobes from the winner; all zero when idle or in reset.
   always_comb begin
      gnt       = 3'b000;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_we    = 1'b0;
      if (w_any) begin
         gnt[w_win] = 1'b1;
         mem_addr   = w_addr_p[w_win];
         mem_wdata  = w_wdata_p[w_win];
         mem_we     = we[w_win];
      end
   end

   // FSM state, lock owner, lock counter and timeout pulse registers.
   always_ff @(posedge clk) begin
      if (!clear) begin
         r_state      <= ST_IDLE;
         r_owner      <= 2'd0;
         r_lcnt       <= 8'd0;
         r_lock_break <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_owner      <= w_owner_nxt;
         r_lcnt       <= w_lcnt_nxt;
         r_lock_break <= w_break_nxt;
      end
   end

   assign w_rd_head = gnt & ~we;

   // Read-valid pipeline: a granted read surfaces on rvalid RD_LAT cycles later.
   always_ff @(posedge clk) begin
      if (!clear) begin
         for (int i = 0; i < int'(RD_LAT); i++) begin
            r_rv[i] <= 3'b000;
         end
      end else begin
         r_rv[0] <= w_rd_head;
         for (int i = 1; i < int'(RD_LAT); i++) begin
            r_rv[i] <= r_rv[i-1];
         end
      end
   end

   assign rvalid     = clear ? r_rv[RD_LAT-1] : 3'b000;
   assign rdata      = mem_rdata;
   assign lock_break = r_lock_break;

endmodule

// File: doc/tile_mem_arbiter.md
# tile_mem_arbiter

Shares the single-port 16×8 tile RAM between three requesters:
- port 0: the in-game FSM;
- port 1: the board loader, which writes shuffled tile words at game start;
- port 2: the VGA tile renderer.

Each cycle the block picks at most one requester and drives the RAM address, write-data and write-enable from that requester. It routes RAM read data back with a per-port valid strobe. A lock mechanism lets one port hold the RAM for a burst, and a timeout forces the lock to release.

## Interface
Parameters:
- AW, 4, address width (16 tiles).
- DW, 8, tile word width. Bits 7:2 hold the tile id, bit 1 the flip flag, bit 0 the cursor flag.
- RD_LAT, 1, RAM read latency in cycles. Legal values are 1 and 2.
- LOCK_MAX, 16, maximum number of consecutive cycles a lock may be held. Legal range is 2..255.

Ports:
- clk  in  1  system clock, 50 MHz.
- clear  in  1  synchronous, active-low reset.
- req  in  3  per-port access request, held until granted.
- we  in  3  per-port write enable (1 = write, 0 = read).
- addr  in  3*AW  per-port address; port i uses bits [i*AW +: AW].
- wdata  in  3*DW  per-port write data; port i uses bits [i*DW +: DW].
- lock  in  3  per-port lock request, sampled only at grant.
- gnt  out  3  one-hot grant, combinational, valid in the current cycle.
- rvalid  out  3  one-hot read-data valid strobe.
- rdata  out  DW  read data, shared by all ports.
- lock_break  out  1  one-cycle pulse when a lock is forcibly released.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_we  out  1  RAM write enable.
- mem_rdata  in  DW  RAM read data; valid RD_LAT cycles after the address.

## Operation
- **States.** The block has two states, IDLE and LOCKED. Registered state also includes:
  - a round-robin pointer `ptr` (2 bits, values 0..2);
  - `owner` (2 bits);
  - a lock counter `lcnt` (8 bits);
  - a read-valid pipeline, RD_LAT stages × 3 bits.
- **IDLE arbitration.**
  - The winner is the first port with `req` set, searching in the order ptr, ptr+1, ptr+2, modulo 3.
  - `gnt[winner]` is 1. mem_addr, mem_wdata and mem_we are taken from the winner's fields.
  - After a grant to port w with `lock[w]=0`: `ptr <= (w+1) mod 3`.
  - After a grant to port w with `lock[w]=1`: `owner <= w`, `lcnt <= 1`, next state LOCKED. `ptr` is unchanged.
- **LOCKED.**
  - Only `owner` can be granted. Other requests wait, and `gnt` for those ports is 0.
  - If `req[owner]=1`, the owner is granted.
  - Exit to IDLE when `lock[owner]=0`. The access made in the exit cycle is still granted. Then `ptr <= owner+1`.
  - `lcnt` increments every LOCKED cycle. When `lcnt == LOCK_MAX-1`:
    - that cycle's owner access is granted;
    - next state is IDLE, `ptr <= owner+1`;
    - `lock_break` pulses in the following cycle.
- **No grant.** When nothing is granted: mem_we=0, mem_addr=0, mem_wdata=0, gnt=000.
- **Read data.**
  - A granted read (`we[i]=0`) sets bit i at the head of the read-valid pipeline.
  - `rvalid[i]` is asserted exactly RD_LAT cycles after the grant cycle.
  - `rdata` equals `mem_rdata` and is passed through combinationally.
  - A granted write produces no rvalid.
- **Requester rule.** A requester holds req, we, addr and wdata stable until it samples `gnt` high at a clock edge. It may issue back-to-back requests.
- **Hazards.** None: single port, ordered accesses. A write granted in cycle T is visible to any read granted in cycle T+1 or later.

## Timing
- gnt and mem_* are combinational from req, lock and registered state. The RAM registers them at the end of the grant cycle.
- Throughput: one access per cycle. Grant latency is 0 cycles when uncontended.
- Worst-case wait with no locks: 2 cycles. With locks: 2·LOCK_MAX cycles.
- Reset (clear=0 at posedge):
  - state IDLE, ptr=0, owner=0, lcnt=0;
  - read-valid pipeline cleared, so in-flight rvalid is dropped;
  - lock_break=0.
- While clear=0: gnt=000, mem_we=0, mem_addr=0, mem_wdata=0, rvalid=000.
- Reset mid-LOCKED: the lock is abandoned without a lock_break pulse.
- If lock and lock-timeout exit coincide, only a single IDLE transition occurs and lock_break still pulses.

## Configuration
- TILE_ARB_RR_EN defined: round-robin as described above.
- Not defined: fixed priority 0 > 1 > 2. `ptr` is not implemented and the search always starts at port 0. Lock and timeout behave identically in both modes.

## Test plan
- **Reset:** clear=0 for 3 cycles with req=111 and we=000 → gnt=000, mem_we=0, rvalid=000. Release clear → first grant goes to port 0, rvalid=001 RD_LAT cycles later.
- **Round-robin (TILE_ARB_RR_EN):** all ports read continuously at addrs 1, 2, 3 → gnt sequence 001, 010, 100, 001…; each rvalid lags its gnt by RD_LAT; rdata equals RAM contents.
- **Write/read ordering:** port 1 writes 8'h2A to addr 5 in cycle T; port 2 reads addr 5 in cycle T+1 → rvalid=100 with rdata=8'h2A.
- **Lock:** port 1 holds lock=1 for 5 grants while port 0 requests → port 0 gnt=0 for those cycles and is granted the cycle after lock drops; lock_break stays 0.
- **Timeout:** LOCK_MAX=16; port 2 holds lock and req for 40 cycles while port 0 requests → port 2 is granted 16 consecutive cycles, lock_break pulses once, port 0 is granted on the next cycle.
- **Fixed priority (macro off):** ports 0 and 2 request continuously → port 2 is never granted; drop req[0] → port 2 is granted in the same cycle.
